pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, 32, width of each of the two data payloads (ALU result, memory data).
REQ-002 Parameter CTRL_W, 2, width of control bundle; bit0 = RegWrite, bit1 = MemtoReg, higher bits opaque.
REQ-003 Parameter ADDR_W, 5, destination register address width.
REQ-004 Parameter CNT_W, 8, stall counter width.
REQ-005 Port clk_i  input  1  clock; all state updates on rising edge.
REQ-006 Port rst_i  input  1  reset, synchronous and active-high.
REQ-007 Port flush_i  input  1  discard stage contents and same-cycle input.
REQ-008 Port valid_i / ready_o  input / output  1 / 1  upstream handshake.
REQ-009 Port ctrl_i, alu_i, mem_i, rd_i  input  CTRL_W, DATA_W, DATA_W, ADDR_W  upstream payload.
REQ-010 Port valid_o / ready_i  output / input  1 / 1  downstream handshake.
REQ-011 Port ctrl_o, alu_o, mem_o, rd_o  output  CTRL_W, DATA_W, DATA_W, ADDR_W  registered payload.
REQ-012 Port stall_cnt_o  output  CNT_W  cycles spent with valid_o=1 and ready_i=0.

Function
REQ-013 In-transfer SHALL occur on a cycle with valid_i=1 and ready_o=1; out-transfer on valid_o=1 and ready_i=1.
REQ-014 Latency SHALL be exactly one cycle from in-transfer to valid_o when the stage is empty or draining.
REQ-015 Payload outputs SHALL change only on a load; on stall they SHALL hold their values bit-exact.
REQ-016 ctrl_o SHALL be all-zero whenever valid_o=0 (bubble: no RegWrite).
REQ-017 On out-transfer without in-transfer, valid_o SHALL drop to 0 next cycle and ctrl_o SHALL clear.
REQ-018 Simultaneous in- and out-transfer SHALL load the new payload, valid_o stays 1.
REQ-019 flush_i=1 SHALL, next cycle, force valid_o=0, ctrl_o=0, empty any skid entry, and drop same-cycle input; alu_o/mem_o/rd_o may hold.
REQ-020 stall_cnt_o SHALL increment by 1 on each cycle with valid_o=1, ready_i=0, saturate at 2^CNT_W-1, clear only on reset or flush.
REQ-021 Priority SHALL be rst_i > flush_i > handshake updates.

Reset
REQ-022 With rst_i=1 at a clock edge, valid_o, ctrl_o, alu_o, mem_o, rd_o, stall_cnt_o and skid state SHALL all become 0.
REQ-023 Reset asserted mid-transfer SHALL discard all in-flight data; ready_o SHALL be 1 on the first cycle after reset.

Configuration
REQ-024 Macro PIPE_STAGE_SKID_EN SHALL select a registered-ready variant.
REQ-025 Without PIPE_STAGE_SKID_EN: ready_o = ready_i | ~valid_o (combinational), single entry.
REQ-026 With PIPE_STAGE_SKID_EN: one extra skid entry; ready_o is a flop output, 0 only while skid is full.
REQ-027 With skid: in-transfer while main full and not draining SHALL park in skid; on next out-transfer skid SHALL move to main; order SHALL be preserved, no loss, no duplication.

Structure
REQ-028 Package pipe_pkg SHALL hold default widths and control bit indices (CTRL_REGWRITE=0, CTRL_MEMTOREG=1).
REQ-029 Saturating counter SHALL be sub-module pipe_sat_cnt (inputs inc, clr; param CNT_W).

Verification
REQ-030 Pass-through: ready_i=1, push alu 0x0000_00AA, rd 5, ctrl 2'b11 -> next cycle valid_o=1, alu_o=0xAA, rd_o=5, ctrl_o=2'b11.
REQ-031 Stall: hold ready_i=0 for 3 cycles with stage full -> payload unchanged, stall_cnt_o=3; with CNT_W=2, 5 cycles -> stall_cnt_o=3.
REQ-032 Flush: stage full, flush_i=1 with valid_i=1, alu 0x55 -> next cycle valid_o=0, ctrl_o=0, stall_cnt_o=0, 0x55 never appears.
REQ-033 Skid (macro on): ready_i=0, push A=0x1 then B=0x2 -> ready_o=0 after B; ready_i=1 -> alu_o shows 0x1 then 0x2 on successive cycles.
REQ-034 Reset mid-stall: stage full, ready_i=0, rst_i=1 one cycle -> all outputs 0, ready_o=1 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths and control-bundle bit positions for the pipeline stage register.
// Imported by pipe_sat_cnt and pipe_stage_reg.
package pipe_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CTRL_W_DEF = 2;
   localparam int ADDR_W_DEF = 5;
   localparam int CNT_W_DEF  = 8;

   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMTOREG = 1;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous reset and clear.
// Ports: clk_i, rst_i, inc (count enable), clr (clear), cnt_o (current count).
module pipe_sat_cnt
   import pipe_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register carrying ctrl, ALU result, memory data and rd.
// Ports: clk_i, rst_i (sync, high), flush_i; upstream valid_i/ready_o + ctrl_i/alu_i/mem_i/rd_i;
// downstream valid_o/ready_i + ctrl_o/alu_o/mem_o/rd_o; stall_cnt_o (saturating stall cycles).
// Define PIPE_STAGE_SKID_EN for a registered ready_o backed by one extra skid entry.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] alu_i,
   input  logic [DATA_W-1:0] mem_i,
   input  logic [ADDR_W-1:0] rd_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] alu_o,
   output logic [DATA_W-1:0] mem_o,
   output logic [ADDR_W-1:0] rd_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   logic              valid_d, valid_q;
   logic [CTRL_W-1:0] ctrl_d, ctrl_q;
   logic [DATA_W-1:0] alu_d, alu_q;
   logic [DATA_W-1:0] mem_d, mem_q;
   logic [ADDR_W-1:0] rd_d, rd_q;

   logic in_xfer;
   logic out_xfer;

   assign out_xfer = valid_q & ready_i;

`ifdef PIPE_STAGE_SKID_EN

   logic              skid_valid_d, skid_valid_q;
   logic [CTRL_W-1:0] skid_ctrl_d, skid_ctrl_q;
   logic [DATA_W-1:0] skid_alu_d, skid_alu_q;
   logic [DATA_W-1:0] skid_mem_d, skid_mem_q;
   logic [ADDR_W-1:0] skid_rd_d, skid_rd_q;
   logic              ready_d, ready_q;

   assign ready_o = ready_q;
   assign in_xfer = valid_i & ready_q & ~flush_i;

   always_comb begin
      valid_d      = valid_q;
      ctrl_d       = ctrl_q;
      alu_d        = alu_q;
      mem_d        = mem_q;
      rd_d         = rd_q;
      skid_valid_d = skid_valid_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_alu_d   = skid_alu_q;
      skid_mem_d   = skid_mem_q;
      skid_rd_d    = skid_rd_q;
      if (flush_i) begin
         valid_d      = 1'b0;
         ctrl_d       = '0;
         skid_valid_d = 1'b0;
         skid_ctrl_d  = '0;
      end else if (out_xfer) begin
         // ready_o is low while the skid is full, so no input can
         // arrive in the same cycle the skid entry is promoted.
         if (skid_valid_q) begin
            valid_d      = 1'b1;
            ctrl_d       = skid_ctrl_q;
            alu_d        = skid_alu_q;
            mem_d        = skid_mem_q;
            rd_d         = skid_rd_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
         end else if (in_xfer) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            alu_d   = alu_i;
            mem_d   = mem_i;
            rd_d    = rd_i;
         end else begin
            valid_d = 1'b0;
            ctrl_d  = '0;
         end
      end else if (in_xfer) begin
         if (valid_q) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = ctrl_i;
            skid_alu_d   = alu_i;
            skid_mem_d   = mem_i;
            skid_rd_d    = rd_i;
         end else begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            alu_d   = alu_i;
            mem_d   = mem_i;
            rd_d    = rd_i;
         end
      end
      ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         skid_valid_q <= 1'b0;
         skid_ctrl_q  <= '0;
         skid_alu_q   <= '0;
         skid_mem_q   <= '0;
         skid_rd_q    <= '0;
         ready_q      <= 1'b1;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_ctrl_q  <= skid_ctrl_d;
         skid_alu_q   <= skid_alu_d;
         skid_mem_q   <= skid_mem_d;
         skid_rd_q    <= skid_rd_d;
         ready_q      <= ready_d;
      end
   end

`else

   // Accept when empty or when the held entry leaves this cycle.
   assign ready_o = ready_i | ~valid_q;
   assign in_xfer = valid_i & ready_o & ~flush_i;

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      alu_d   = alu_q;
      mem_d   = mem_q;
      rd_d    = rd_q;
      if (flush_i) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (in_xfer) begin
         valid_d = 1'b1;
         ctrl_d  = ctrl_i;
         alu_d   = alu_i;
         mem_d   = mem_i;
         rd_d    = rd_i;
      end else if (out_xfer) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end
   end

`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         alu_q   <= '0;
         mem_q   <= '0;
         rd_q    <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         alu_q   <= alu_d;
         mem_q   <= mem_d;
         rd_q    <= rd_d;
      end
   end

   pipe_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc   (valid_q & ~ready_i),
      .clr   (flush_i),
      .cnt_o (stall_cnt_o)
   );

   assign valid_o = valid_q;
   assign ctrl_o  = ctrl_q;
   assign alu_o   = alu_q;
   assign mem_o   = mem_q;
   assign rd_o    = rd_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic        clk;
   logic        rst_i, flush_i, valid_i, ready_i;
   logic        ready_o, valid_o;
   logic [1:0]  ctrl_i, ctrl_o;
   logic [31:0] alu_i, mem_i, alu_o, mem_o;
   logic [4:0]  rd_i, rd_o;
   logic [7:0]  stall_cnt_o;

   pipe_stage_reg dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .ctrl_i      (ctrl_i),
      .alu_i       (alu_i),
      .mem_i       (mem_i),
      .rd_i        (rd_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .ctrl_o      (ctrl_o),
      .alu_o       (alu_o),
      .mem_o       (mem_o),
      .rd_o        (rd_o),
      .stall_cnt_o (stall_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  ctrl;
      logic [31:0] alu;
      logic [31:0] mem;
      logic [4:0]  rd;
   } item_t;

   typedef struct {
      logic        rst, fl, v, r;
      logic [1:0]  c;
      logic [31:0] a;
      logic [4:0]  d;
      logic        chk_rdy, e_rdy, e_v;
      logic [1:0]  e_c;
      logic [31:0] e_a;
      logic [4:0]  e_d;
      logic [7:0]  e_cnt;
   } row_t;

   item_t       q[$];
   item_t       last;
   int          m_cnt;
   bit          known;
   int          checks;
   int          errors;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
      end
   endtask

   // One clock: drive, sample comb ready, update model, check registered outputs.
   task automatic step(input logic rst, input logic fl, input logic v, input logic r,
                       input logic [1:0] c, input logic [31:0] a, input logic [31:0] m,
                       input logic [4:0] d, output logic rdy_pre);
      logic  exp_rdy;
      item_t it;
      rst_i   = rst;
      flush_i = fl;
      valid_i = v;
      ready_i = r;
      ctrl_i  = c;
      alu_i   = a;
      mem_i   = m;
      rd_i    = d;
      #2;
      rdy_pre = ready_o;
      exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || r);
      if (known) chk("model_ready_o", {63'd0, ready_o}, {63'd0, exp_rdy});
      if (rst) begin
         q.delete();
         last  = '{2'd0, 32'd0, 32'd0, 5'd0};
         m_cnt = 0;
      end else if (fl) begin
         q.delete();
         m_cnt = 0;
      end else begin
         if (q.size() > 0 && !r && m_cnt < 255) m_cnt++;
         if (q.size() > 0 && r) void'(q.pop_front());
         if (v && exp_rdy) begin
            it = '{c, a, m, d};
            q.push_back(it);
         end
         if (q.size() > 0) last = q[0];
      end
      @(posedge clk);
      #1;
      if (rst) known = 1'b1;
      if (known) begin
         chk("model_valid_o", {63'd0, valid_o}, {63'd0, q.size() > 0});
         chk("model_ctrl_o", {62'd0, ctrl_o}, {62'd0, (q.size() > 0) ? q[0].ctrl : 2'd0});
         chk("model_alu_o", {32'd0, alu_o}, {32'd0, last.alu});
         chk("model_mem_o", {32'd0, mem_o}, {32'd0, last.mem});
         chk("model_rd_o", {59'd0, rd_o}, {59'd0, last.rd});
         chk("model_stall_cnt", {56'd0, stall_cnt_o}, 64'(m_cnt));
      end
   endtask

   function automatic row_t mk(input logic rst, input logic fl, input logic v, input logic r,
                               input logic [1:0] c, input logic [31:0] a, input logic [4:0] d,
                               input logic chk_rdy, input logic e_rdy, input logic e_v,
                               input logic [1:0] e_c, input logic [31:0] e_a,
                               input logic [4:0] e_d, input logic [7:0] e_cnt);
      row_t x;
      x = '{rst, fl, v, r, c, a, d, chk_rdy, e_rdy, e_v, e_c, e_a, e_d, e_cnt};
      return x;
   endfunction

   row_t tbl[14];
   logic rp;

   initial begin
      checks = 0;
      errors = 0;
      known  = 1'b0;
      m_cnt  = 0;
      last   = '{2'd0, 32'd0, 32'd0, 5'd0};

`ifndef PIPE_STAGE_SKID_EN
      tbl[0]  = mk(1, 0, 0, 0, 2'd0, 32'h0,        5'd0,  0, 0, 0, 2'd0, 32'h0,        5'd0,  8'd0);
      tbl[1]  = mk(0, 0, 1, 1, 2'd3, 32'hAA,       5'd5,  1, 1, 1, 2'd3, 32'hAA,       5'd5,  8'd0);
      tbl[2]  = mk(0, 0, 0, 0, 2'd0, 32'h0,        5'd0,  1, 0, 1, 2'd3, 32'hAA,       5'd5,  8'd1);
      tbl[3]  = mk(0, 0, 1, 0, 2'd1, 32'h77,       5'd7,  1, 0, 1, 2'd3, 32'hAA,       5'd5,  8'd2);
      tbl[4]  = mk(0, 0, 0, 0, 2'd0, 32'h0,        5'd0,  1, 0, 1, 2'd3, 32'hAA,       5'd5,  8'd3);
      tbl[5]  = mk(0, 1, 1, 0, 2'd3, 32'h55,       5'd9,  1, 0, 0, 2'd0, 32'hAA,       5'd5,  8'd0);
      tbl[6]  = mk(0, 0, 0, 1, 2'd0, 32'h0,        5'd0,  1, 1, 0, 2'd0, 32'hAA,       5'd5,  8'd0);
      tbl[7]  = mk(0, 0, 1, 0, 2'd2, 32'h12345678, 5'd31, 1, 1, 1, 2'd2, 32'h12345678, 5'd31, 8'd0);
      tbl[8]  = mk(0, 0, 1, 1, 2'd1, 32'hDEADBEEF, 5'd1,  1, 1, 1, 2'd1, 32'hDEADBEEF, 5'd1,  8'd0);
      tbl[9]  = mk(0, 0, 0, 1, 2'd0, 32'h0,        5'd0,  1, 1, 0, 2'd0, 32'hDEADBEEF, 5'd1,  8'd0);
      tbl[10] = mk(0, 0, 1, 0, 2'd3, 32'hAB,       5'd2,  1, 1, 1, 2'd3, 32'hAB,       5'd2,  8'd0);
      tbl[11] = mk(0, 0, 0, 0, 2'd0, 32'h0,        5'd0,  1, 0, 1, 2'd3, 32'hAB,       5'd2,  8'd1);
      tbl[12] = mk(1, 0, 1, 0, 2'd3, 32'h99,       5'd3,  1, 0, 0, 2'd0, 32'h0,        5'd0,  8'd0);
      tbl[13] = mk(0, 0, 0, 0, 2'd0, 32'h0,        5'd0,  1, 1, 0, 2'd0, 32'h0,        5'd0,  8'd0);

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].rst, tbl[i].fl, tbl[i].v, tbl[i].r, tbl[i].c,
              tbl[i].a, ~tbl[i].a, tbl[i].d, rp);
         if (tbl[i].chk_rdy) chk($sformatf("tbl%0d_ready_o", i), {63'd0, rp}, {63'd0, tbl[i].e_rdy});
         chk($sformatf("tbl%0d_valid_o", i), {63'd0, valid_o}, {63'd0, tbl[i].e_v});
         chk($sformatf("tbl%0d_ctrl_o", i), {62'd0, ctrl_o}, {62'd0, tbl[i].e_c});
         chk($sformatf("tbl%0d_alu_o", i), {32'd0, alu_o}, {32'd0, tbl[i].e_a});
         chk($sformatf("tbl%0d_rd_o", i), {59'd0, rd_o}, {59'd0, tbl[i].e_d});
         chk($sformatf("tbl%0d_stall_cnt", i), {56'd0, stall_cnt_o}, {56'd0, tbl[i].e_cnt});
      end
`else
      step(1, 0, 0, 0, 2'd0, 32'h0, 32'h0, 5'd0, rp);
      chk("rst_ready_o", {63'd0, ready_o}, 64'd1);
      step(0, 0, 1, 0, 2'd1, 32'h1, 32'h10, 5'd1, rp);
      step(0, 0, 1, 0, 2'd3, 32'h2, 32'h20, 5'd2, rp);
      chk("skid_full_ready_o", {63'd0, ready_o}, 64'd0);
      chk("skid_head_alu", {32'd0, alu_o}, 64'h1);
      step(0, 0, 0, 1, 2'd0, 32'h0, 32'h0, 5'd0, rp);
      chk("skid_second_alu", {32'd0, alu_o}, 64'h2);
      chk("skid_second_valid", {63'd0, valid_o}, 64'd1);
      chk("skid_second_ctrl", {62'd0, ctrl_o}, 64'd3);
      step(0, 0, 0, 1, 2'd0, 32'h0, 32'h0, 5'd0, rp);
      chk("skid_drained_valid", {63'd0, valid_o}, 64'd0);
      step(0, 0, 1, 0, 2'd1, 32'h3, 32'h30, 5'd3, rp);
      step(0, 0, 1, 0, 2'd1, 32'h4, 32'h40, 5'd4, rp);
      step(0, 1, 1, 0, 2'd1, 32'h55, 32'h55, 5'd5, rp);
      chk("skid_flush_valid", {63'd0, valid_o}, 64'd0);
      chk("skid_flush_ready", {63'd0, ready_o}, 64'd1);
      chk("skid_flush_alu", {32'd0, alu_o}, 64'h3);
`endif

      // Stall counter saturation.
      step(1, 0, 0, 0, 2'd0, 32'h0, 32'h0, 5'd0, rp);
      step(0, 0, 1, 0, 2'd1, 32'hC0FFEE, 32'h1, 5'd4, rp);
      for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 2'd0, 32'h0, 32'h0, 5'd0, rp);
      chk("sat_stall_cnt", {56'd0, stall_cnt_o}, 64'd255);
      chk("sat_alu_hold", {32'd0, alu_o}, 64'hC0FFEE);
      step(0, 1, 0, 0, 2'd0, 32'h0, 32'h0, 5'd0, rp);
      chk("flush_clears_cnt", {56'd0, stall_cnt_o}, 64'd0);

      // Randomized traffic against the queue model.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
              2'($urandom), $urandom, $urandom, 5'($urandom), rp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
